// File: rtl/ddr_port_arbiter_pkg.sv
// Shared definitions for the two-requester DDR port arbiter:
// FSM state encoding, default bus widths and a grant helper.
package ddr_arb_pkg;

    localparam int DATA_W_DEF = 128;
    localparam int ADDR_W_DEF = 32;
    localparam int ID_W_DEF   = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_WRESP = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = S_IDLE,
        ADDR  = S_ADDR,
        WRITE = S_WRITE,
        WRESP = S_WRESP,
        READ  = S_READ
    } arb_state_e;

    function automatic logic [1:0] onehot2(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ddr_port_arbiter_if.sv
// One DDR-style port: combined address channel plus W/R/B channels.
// master drives requests, slave answers them.
interface ddr_port_arbiter_if #(
    parameter int DATA_WIDTH = ddr_arb_pkg::DATA_W_DEF,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = ddr_arb_pkg::ADDR_W_DEF,
    parameter int ID_WIDTH   = ddr_arb_pkg::ID_W_DEF
);

    logic [ID_WIDTH-1:0]   aid;
    logic [ADDR_WIDTH-1:0] aaddr;
    logic [7:0]            alen;
    logic [2:0]            asize;
    logic [1:0]            aburst;
    logic [1:0]            alock;
    logic                  atype;
    logic                  avalid;
    logic                  aready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    logic [ID_WIDTH-1:0]   bid;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output aid, aaddr, alen, asize, aburst, alock, atype, avalid,
        input  aready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        input  bid, bvalid,
        output bready
    );

    modport slave (
        input  aid, aaddr, alen, asize, aburst, alock, atype, avalid,
        output aready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        output bid, bvalid,
        input  bready
    );

endinterface

// File: rtl/ddr_port_arbiter_rr_arb2.sv
// Two-way round-robin pick; the pointer is owned by the parent
// and only consulted when both requesters are asking.
module ddr_rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       owner,
    output logic       valid
);

    always_comb begin
        owner = 1'b0;
        unique case (req)
            2'b11:   owner = ptr;
            2'b10:   owner = 1'b1;
            default: owner = 1'b0;
        endcase
    end

    assign valid = |req;

endmodule

// File: rtl/ddr_port_arbiter.sv
// Shares one serialised DDR port between two requesters, one whole
// transaction at a time, with a sticky wlast/alen mismatch flag.
module ddr_port_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int ID_WIDTH   = ID_W_DEF
) (
    input  logic              mem_clk,
    input  logic              reset,
    ddr_port_arbiter_if.slave  s0,
    ddr_port_arbiter_if.slave  s1,
    ddr_port_arbiter_if.master m,
    output logic [1:0]        grant,
    output logic              err_wlast,
    input  logic              err_clr
);

    arb_state_e state;
    logic       owner;
    logic       rr_ptr;
    logic [7:0] beat_cnt;
    logic [7:0] alen_q;

    logic arb_owner;
    logic arb_valid;

    logic [ID_WIDTH-1:0]   sel_aid;
    logic [ADDR_WIDTH-1:0] sel_aaddr;
    logic [7:0]            sel_alen;
    logic [2:0]            sel_asize;
    logic [1:0]            sel_aburst;
    logic [1:0]            sel_alock;
    logic                  sel_atype;
    logic                  sel_avalid;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [STRB_WIDTH-1:0] sel_wstrb;
    logic                  sel_wlast;
    logic                  sel_wvalid;
    logic                  sel_rready;
    logic                  sel_bready;

    logic a_hs;
    logic w_hs;
    logic r_done;
    logic b_hs;
    logic w_final;
    logic w_bad;

    ddr_rr_arb2 u_rr (
        .req   ({s1.avalid, s0.avalid}),
        .ptr   (rr_ptr),
        .owner (arb_owner),
        .valid (arb_valid)
    );

    assign sel_aid    = owner ? s1.aid    : s0.aid;
    assign sel_aaddr  = owner ? s1.aaddr  : s0.aaddr;
    assign sel_alen   = owner ? s1.alen   : s0.alen;
    assign sel_asize  = owner ? s1.asize  : s0.asize;
    assign sel_aburst = owner ? s1.aburst : s0.aburst;
    assign sel_alock  = owner ? s1.alock  : s0.alock;
    assign sel_atype  = owner ? s1.atype  : s0.atype;
    assign sel_avalid = owner ? s1.avalid : s0.avalid;
    assign sel_wdata  = owner ? s1.wdata  : s0.wdata;
    assign sel_wstrb  = owner ? s1.wstrb  : s0.wstrb;
    assign sel_wlast  = owner ? s1.wlast  : s0.wlast;
    assign sel_wvalid = owner ? s1.wvalid : s0.wvalid;
    assign sel_rready = owner ? s1.rready : s0.rready;
    assign sel_bready = owner ? s1.bready : s0.bready;

    assign a_hs   = (state == ADDR)  & sel_avalid & m.aready;
    assign w_hs   = (state == WRITE) & sel_wvalid & m.wready;
    assign r_done = (state == READ)  & m.rvalid & sel_rready & m.rlast;
    assign b_hs   = (state == WRESP) & m.bvalid & sel_bready;

    // burst length is governed by alen; wlast is only cross-checked
    assign w_final = (beat_cnt == alen_q);
    assign w_bad   = w_hs & (sel_wlast != w_final);

    always_ff @(posedge mem_clk) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            rr_ptr    <= 1'b0;
            beat_cnt  <= 8'd0;
            alen_q    <= 8'd0;
            grant     <= 2'b00;
            err_wlast <= 1'b0;
        end else begin
            err_wlast <= w_bad | (err_wlast & ~err_clr);
            unique case (state)
                IDLE: begin
                    if (arb_valid) begin
                        owner <= arb_owner;
                        grant <= onehot2(arb_owner);
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (a_hs) begin
                        alen_q   <= sel_alen;
                        beat_cnt <= 8'd0;
                        state    <= sel_atype ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (w_final) state <= WRESP;
                    end
                end
                WRESP: begin
                    if (b_hs) begin
                        rr_ptr <= ~owner;
                        grant  <= 2'b00;
                        state  <= IDLE;
                    end
                end
                READ: begin
                    if (r_done) begin
                        rr_ptr <= ~owner;
                        grant  <= 2'b00;
                        state  <= IDLE;
                    end
                end
                default: begin
                    grant <= 2'b00;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        m.aid    = '0;
        m.aaddr  = '0;
        m.alen   = '0;
        m.asize  = '0;
        m.aburst = '0;
        m.alock  = '0;
        m.atype  = 1'b0;
        m.avalid = 1'b0;
        m.wdata  = '0;
        m.wstrb  = '0;
        m.wlast  = 1'b0;
        m.wvalid = 1'b0;
        m.rready = 1'b0;
        m.bready = 1'b0;

        s0.aready = 1'b0;
        s0.wready = 1'b0;
        s0.rid    = '0;
        s0.rdata  = '0;
        s0.rresp  = '0;
        s0.rlast  = 1'b0;
        s0.rvalid = 1'b0;
        s0.bid    = '0;
        s0.bvalid = 1'b0;

        s1.aready = 1'b0;
        s1.wready = 1'b0;
        s1.rid    = '0;
        s1.rdata  = '0;
        s1.rresp  = '0;
        s1.rlast  = 1'b0;
        s1.rvalid = 1'b0;
        s1.bid    = '0;
        s1.bvalid = 1'b0;

        unique case (state)
            ADDR: begin
                m.aid    = sel_aid;
                m.aaddr  = sel_aaddr;
                m.alen   = sel_alen;
                m.asize  = sel_asize;
                m.aburst = sel_aburst;
                m.alock  = sel_alock;
                m.atype  = sel_atype;
                m.avalid = sel_avalid;
                if (owner) s1.aready = m.aready;
                else       s0.aready = m.aready;
            end
            WRITE: begin
                m.wdata  = sel_wdata;
                m.wstrb  = sel_wstrb;
                m.wlast  = sel_wlast;
                m.wvalid = sel_wvalid;
                if (owner) s1.wready = m.wready;
                else       s0.wready = m.wready;
            end
            WRESP: begin
                m.bready = sel_bready;
                if (owner) begin
                    s1.bid    = m.bid;
                    s1.bvalid = m.bvalid;
                end else begin
                    s0.bid    = m.bid;
                    s0.bvalid = m.bvalid;
                end
            end
            READ: begin
                m.rready = sel_rready;
                if (owner) begin
                    s1.rid    = m.rid;
                    s1.rdata  = m.rdata;
                    s1.rresp  = m.rresp;
                    s1.rlast  = m.rlast;
                    s1.rvalid = m.rvalid;
                end else begin
                    s0.rid    = m.rid;
                    s0.rdata  = m.rdata;
                    s0.rresp  = m.rresp;
                    s0.rlast  = m.rlast;
                    s0.rvalid = m.rvalid;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Bench for ddr_port_arbiter: two requester drivers, a DDR memory
// model and a transaction-level reference for data, ids and order.
module tb_ddr_port_arbiter;
    import ddr_arb_pkg::*;

    localparam int DW  = 128;
    localparam int AW  = 32;
    localparam int IW  = 8;
    localparam int TMO = 400;

    logic       mem_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       err_clr = 1'b0;
    logic [1:0] grant;
    logic       err_wlast;

    ddr_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) s0_if ();
    ddr_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) s1_if ();
    ddr_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) m_if ();

    ddr_port_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .ID_WIDTH   (IW)
    ) dut (
        .mem_clk   (mem_clk),
        .reset     (reset),
        .s0        (s0_if),
        .s1        (s1_if),
        .m         (m_if),
        .grant     (grant),
        .err_wlast (err_wlast),
        .err_clr   (err_clr)
    );

    always #5 mem_clk = ~mem_clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // requester-side drive registers
    logic [IW-1:0] q_aid[2];
    logic [AW-1:0] q_aaddr[2];
    logic [7:0]    q_alen[2];
    logic          q_atype[2];
    logic          q_avalid[2];
    logic [DW-1:0] q_wdata[2];
    logic          q_wlast[2];
    logic          q_wvalid[2];
    logic          q_rready[2];
    logic          q_bready[2];

    assign s0_if.aid = q_aid[0];       assign s1_if.aid = q_aid[1];
    assign s0_if.aaddr = q_aaddr[0];   assign s1_if.aaddr = q_aaddr[1];
    assign s0_if.alen = q_alen[0];     assign s1_if.alen = q_alen[1];
    assign s0_if.asize = 3'd4;         assign s1_if.asize = 3'd4;
    assign s0_if.aburst = 2'b01;       assign s1_if.aburst = 2'b01;
    assign s0_if.alock = 2'b00;        assign s1_if.alock = 2'b00;
    assign s0_if.atype = q_atype[0];   assign s1_if.atype = q_atype[1];
    assign s0_if.avalid = q_avalid[0]; assign s1_if.avalid = q_avalid[1];
    assign s0_if.wdata = q_wdata[0];   assign s1_if.wdata = q_wdata[1];
    assign s0_if.wstrb = '1;           assign s1_if.wstrb = '1;
    assign s0_if.wlast = q_wlast[0];   assign s1_if.wlast = q_wlast[1];
    assign s0_if.wvalid = q_wvalid[0]; assign s1_if.wvalid = q_wvalid[1];
    assign s0_if.rready = q_rready[0]; assign s1_if.rready = q_rready[1];
    assign s0_if.bready = q_bready[0]; assign s1_if.bready = q_bready[1];

    logic          r_aready[2], r_wready[2], r_rvalid[2], r_rlast[2], r_bvalid[2];
    logic [IW-1:0] r_rid[2], r_bid[2];
    logic [DW-1:0] r_rdata[2];

    assign r_aready[0] = s0_if.aready; assign r_aready[1] = s1_if.aready;
    assign r_wready[0] = s0_if.wready; assign r_wready[1] = s1_if.wready;
    assign r_rvalid[0] = s0_if.rvalid; assign r_rvalid[1] = s1_if.rvalid;
    assign r_rlast[0] = s0_if.rlast;   assign r_rlast[1] = s1_if.rlast;
    assign r_bvalid[0] = s0_if.bvalid; assign r_bvalid[1] = s1_if.bvalid;
    assign r_rid[0] = s0_if.rid;       assign r_rid[1] = s1_if.rid;
    assign r_bid[0] = s0_if.bid;       assign r_bid[1] = s1_if.bid;
    assign r_rdata[0] = s0_if.rdata;   assign r_rdata[1] = s1_if.rdata;

    logic [11:0] outs;
    assign outs = {s0_if.aready, s0_if.wready, s0_if.rvalid, s0_if.bvalid,
                   s1_if.aready, s1_if.wready, s1_if.rvalid, s1_if.bvalid,
                   m_if.avalid, m_if.wvalid, m_if.rready, m_if.bready};

    // reference model state
    logic [DW-1:0] ref_mem [int];
    bit            rr_model  = 1'b0;
    bit            err_model = 1'b0;

    function automatic logic [DW-1:0] fill(input int k);
        return {k, k, k, k};
    endfunction

    function automatic logic [DW-1:0] ref_rd(input int k);
        return ref_mem.exists(k) ? ref_mem[k] : fill(k);
    endfunction

    // DDR memory model
    logic [DW-1:0] ddr_mem [int];
    int            ddr_mode = 0;
    int            d_cnt = 0;
    int            last_wbeats = 0;
    logic [IW-1:0] d_id;
    logic [AW-1:0] d_addr;
    logic [7:0]    d_len;
    bit            ddr_fast = 1'b1;
    bit            r_hold;

    function automatic logic [DW-1:0] ddr_rd(input int k);
        return ddr_mem.exists(k) ? ddr_mem[k] : fill(k);
    endfunction

    initial begin
        m_if.aready = 1'b0; m_if.wready = 1'b0;
        m_if.rid = '0; m_if.rdata = '0; m_if.rresp = '0;
        m_if.rlast = 1'b0; m_if.rvalid = 1'b0;
        m_if.bid = '0; m_if.bvalid = 1'b0;
        forever begin
            @(negedge mem_clk);
            r_hold = (ddr_mode == 2) && m_if.rvalid && !m_if.rready;
            if (reset) begin
                ddr_mode = 0;
                r_hold = 1'b0;
            end else begin
                case (ddr_mode)
                    0: if (m_if.avalid && m_if.aready) begin
                        d_id = m_if.aid; d_addr = m_if.aaddr;
                        d_len = m_if.alen; d_cnt = 0;
                        ddr_mode = m_if.atype ? 1 : 2;
                    end
                    1: if (m_if.wvalid && m_if.wready) begin
                        ddr_mem[int'(d_addr >> 4) + d_cnt] = m_if.wdata;
                        d_cnt++;
                        if (d_cnt == int'(d_len) + 1) begin
                            last_wbeats = d_cnt;
                            ddr_mode = 3;
                        end
                    end
                    2: if (m_if.rvalid && m_if.rready) begin
                        d_cnt++;
                        if (m_if.rlast) ddr_mode = 0;
                    end
                    3: if (m_if.bvalid && m_if.bready) ddr_mode = 0;
                    default: ddr_mode = 0;
                endcase
            end
            @(posedge mem_clk);
            #1;
            m_if.aready = (ddr_mode == 0) && (ddr_fast || ($urandom % 2 == 1));
            m_if.wready = (ddr_mode == 1) && (ddr_fast || ($urandom % 2 == 1));
            if (ddr_mode == 2) begin
                if (!r_hold) begin
                    m_if.rvalid = ($urandom % 4 != 0);
                    m_if.rdata  = ddr_rd(int'(d_addr >> 4) + d_cnt);
                    m_if.rlast  = (d_cnt == int'(d_len));
                    m_if.rid    = d_id;
                end
            end else begin
                m_if.rvalid = 1'b0;
                m_if.rlast  = 1'b0;
            end
            m_if.bvalid = (ddr_mode == 3);
            m_if.bid    = d_id;
        end
    end

    // grant order log and isolation monitor
    int         glog[$];
    int         viol = 0;
    logic [1:0] prev_grant = 2'b00;

    always @(negedge mem_clk) begin
        if (grant != 2'b00 && prev_grant == 2'b00) glog.push_back(int'(grant[1]));
        if (grant == 2'b11) viol++;
        if (!grant[0] && (s0_if.aready | s0_if.wready | s0_if.rvalid | s0_if.bvalid)) viol++;
        if (!grant[1] && (s1_if.aready | s1_if.wready | s1_if.rvalid | s1_if.bvalid)) viol++;
        if (grant == 2'b00 && (m_if.avalid | m_if.wvalid | m_if.rready | m_if.bready)) viol++;
        prev_grant = grant;
    end

    function automatic int last_owner();
        return (glog.size() > 0) ? glog[glog.size() - 1] : -1;
    endfunction

    // one whole transaction from requester p; starts and ends at posedge+1
    task automatic txn(input int p, input bit wr, input logic [7:0] id,
                       input logic [31:0] addr, input logic [7:0] len,
                       input int bad, input bit inc, input bit toggle,
                       output int a_lat);
        int n;
        int beats;
        bit done;
        int k;
        q_aid[p] = id; q_aaddr[p] = addr; q_alen[p] = len;
        q_atype[p] = wr; q_avalid[p] = 1'b1;
        n = 0;
        do begin @(negedge mem_clk); n++; end while (!r_aready[p] && n < TMO);
        a_lat = n;
        chk("aready", r_aready[p], 1'b1);
        if (!r_aready[p]) begin q_avalid[p] = 1'b0; return; end
        @(posedge mem_clk); #1;
        q_avalid[p] = 1'b0;
        k = int'(addr >> 4);
        if (wr) begin
            for (int i = 0; i <= int'(len); i++) begin
                q_wdata[p]  = inc ? 128'(i) : {$urandom, $urandom, $urandom, $urandom};
                q_wlast[p]  = (i == int'(len)) || (i == bad);
                q_wvalid[p] = 1'b1;
                n = 0;
                do begin @(negedge mem_clk); n++; end while (!r_wready[p] && n < TMO);
                chk("wready", r_wready[p], 1'b1);
                if (!r_wready[p]) begin q_wvalid[p] = 1'b0; return; end
                ref_mem[k + i] = q_wdata[p];
                @(posedge mem_clk); #1;
            end
            q_wvalid[p] = 1'b0; q_wlast[p] = 1'b0;
            q_bready[p] = 1'b1;
            n = 0;
            do begin @(negedge mem_clk); n++; end while (!r_bvalid[p] && n < TMO);
            chk("bvalid", r_bvalid[p], 1'b1);
            chk("bid", r_bid[p], id);
            @(posedge mem_clk); #1;
            q_bready[p] = 1'b0;
        end else begin
            beats = 0; done = 1'b0; n = 0;
            while (!done && n < TMO) begin
                q_rready[p] = toggle ? n[0] : 1'b1;
                @(negedge mem_clk);
                n++;
                if (r_rvalid[p] && q_rready[p]) begin
                    chk("rdata", r_rdata[p], ref_rd(k + beats));
                    chk("rid", r_rid[p], id);
                    chk("rlast", r_rlast[p], beats == int'(len));
                    beats++;
                    if (r_rlast[p] || beats > int'(len)) done = 1'b1;
                end
                @(posedge mem_clk); #1;
            end
            q_rready[p] = 1'b0;
            chk("rbeats", beats, int'(len) + 1);
        end
        rr_model = (p == 0);
    endtask

    task automatic pair(input bit w0, input bit w1);
        int  base;
        bit  first;
        int  l0, l1;
        logic [7:0] n0, n1;
        base  = glog.size();
        first = rr_model;
        n0 = 8'($urandom_range(0, 5));
        n1 = 8'($urandom_range(0, 5));
        fork
            txn(0, w0, 8'hA0, 32'h1000 + ($urandom_range(0, 15) << 4), n0, -1, 1'b0, 1'b0, l0);
            txn(1, w1, 8'hB1, 32'h2000 + ($urandom_range(0, 15) << 4), n1, -1, 1'b0, 1'b0, l1);
        join
        chk("glog_n", glog.size(), base + 2);
        if (glog.size() >= base + 2) begin
            chk("rr_first", glog[base], first);
            chk("rr_second", glog[base + 1], !first);
        end
    endtask

    task automatic do_reset();
        @(posedge mem_clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge mem_clk);
        @(negedge mem_clk);
        chk("rst_grant", grant, 2'b00);
        chk("rst_outs", outs, 12'h000);
        chk("rst_err", err_wlast, 1'b0);
        @(posedge mem_clk); #1;
        reset = 1'b0;
        rr_model = 1'b0;
        err_model = 1'b0;
    endtask

    task automatic clr_err();
        err_clr = 1'b1;
        @(posedge mem_clk); #1;
        err_clr = 1'b0;
        err_model = 1'b0;
        @(negedge mem_clk);
        chk("err_clr", err_wlast, 1'b0);
        @(posedge mem_clk); #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        int beats;
        bit wr;
        int p;
        int bad;
        logic [7:0] len;
        for (int i = 0; i < 2; i++) begin
            q_aid[i] = '0; q_aaddr[i] = '0; q_alen[i] = '0;
            q_atype[i] = 1'b0; q_avalid[i] = 1'b0; q_wdata[i] = '0;
            q_wlast[i] = 1'b0; q_wvalid[i] = 1'b0;
            q_rready[i] = 1'b0; q_bready[i] = 1'b0;
        end
        do_reset();

        // simultaneous requests right after reset, twice
        pair(1'b1, 1'b1);
        pair(1'b0, 1'b1);

        // s0 write of 0..3 then read-back through s1
        txn(0, 1'b1, 8'h11, 32'h100, 8'd3, -1, 1'b1, 1'b0, lat);
        chk("t1_owner", last_owner(), 0);
        chk("t1_wbeats", last_wbeats, 4);
        @(negedge mem_clk);
        chk("t1_idle", grant, 2'b00);
        @(posedge mem_clk); #1;
        txn(1, 1'b0, 8'h22, 32'h100, 8'd3, -1, 1'b0, 1'b0, lat);
        chk("t1_rd_owner", last_owner(), 1);

        // long read with stalling rready
        txn(1, 1'b0, 8'h33, 32'h100, 8'd7, -1, 1'b0, 1'b1, lat);

        // wlast early on beat 1 of a 3-beat burst
        txn(0, 1'b1, 8'h44, 32'h200, 8'd2, 1, 1'b0, 1'b0, lat);
        err_model = 1'b1;
        chk("err_wbeats", last_wbeats, 3);
        @(negedge mem_clk);
        chk("err_set", err_wlast, err_model);
        @(posedge mem_clk); #1;
        clr_err();

        // reset during the third read beat
        q_aid[1] = 8'h55; q_aaddr[1] = 32'h300; q_alen[1] = 8'd7;
        q_atype[1] = 1'b0; q_avalid[1] = 1'b1;
        n = 0;
        do begin @(negedge mem_clk); n++; end while (!r_aready[1] && n < TMO);
        chk("mr_aready", r_aready[1], 1'b1);
        @(posedge mem_clk); #1;
        q_avalid[1] = 1'b0; q_rready[1] = 1'b1;
        beats = 0; n = 0;
        while (beats < 2 && n < TMO) begin
            @(negedge mem_clk);
            n++;
            if (r_rvalid[1]) beats++;
            @(posedge mem_clk); #1;
        end
        chk("mr_beats", beats, 2);
        reset = 1'b1; q_rready[1] = 1'b0;
        @(posedge mem_clk);
        @(negedge mem_clk);
        chk("mr_grant", grant, 2'b00);
        chk("mr_outs", outs, 12'h000);
        @(posedge mem_clk); #1;
        reset = 1'b0;
        rr_model = 1'b0;
        txn(1, 1'b0, 8'h66, 32'h300, 8'd1, -1, 1'b0, 1'b0, lat);
        chk("mr_owner", last_owner(), 1);

        // single-beat write and read with an always-ready DDR
        txn(0, 1'b1, 8'h77, 32'h400, 8'd0, -1, 1'b0, 1'b0, lat);
        chk("a0_wlat", lat, 2);
        txn(0, 1'b0, 8'h78, 32'h400, 8'd0, -1, 1'b0, 1'b0, lat);
        chk("a0_rlat", lat, 2);

        // randomized traffic with a stalling DDR
        ddr_fast = 1'b0;
        for (int it = 0; it < 24; it++) begin
            if ($urandom % 3 == 0) begin
                pair(1'($urandom % 2), 1'($urandom % 2));
            end else begin
                p   = $urandom % 2;
                wr  = 1'($urandom % 2);
                len = 8'($urandom_range(0, 7));
                bad = -1;
                if (wr && len > 0 && $urandom % 4 == 0) bad = $urandom_range(0, int'(len) - 1);
                txn(p, wr, 8'($urandom), (p == 1 ? 32'h2000 : 32'h1000) + ($urandom_range(0, 15) << 4),
                    len, bad, 1'b0, 1'($urandom % 2), lat);
                chk("rand_owner", last_owner(), p);
                if (bad >= 0) err_model = 1'b1;
            end
            @(negedge mem_clk);
            chk("rand_err", err_wlast, err_model);
            @(posedge mem_clk); #1;
            if (err_model && $urandom % 2 == 0) clr_err();
        end

        chk("isolation", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
